// File: rtl/ltl_monitor_pkg.sv
// Shared defaults and event-port state encoding for the LTL monitor cluster reporter.
package ltl_monitor_pkg;

  localparam int unsigned DefNumProps  = 10;
  localparam int unsigned DefNumReport = 4;
  localparam int unsigned DefCntW      = 16;
  localparam int unsigned DefTsW       = 32;
  localparam int unsigned DefPidW      = 5;

  typedef enum logic {
    StIdle,
    StPresent
  } evt_state_e;

endpackage

// File: rtl/ltl_rr_arbiter.sv
// Round-robin arbiter: grants the lowest requester at or after the pointer, wrapping around.
module ltl_rr_arbiter #(
  parameter int unsigned NumReq = 10,
  parameter int unsigned IdxW   = 5
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [NumReq-1:0] req_i,
  input  logic              advance_i,
  output logic [NumReq-1:0] grant_o,
  output logic [IdxW-1:0]   idx_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] hi_idx, lo_idx;
  logic            found_hi, found_lo;

  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (req_i[i] && !found_lo) begin
        found_lo = 1'b1;
        lo_idx   = IdxW'(i);
      end
      if (req_i[i] && !found_hi && (IdxW'(i) >= ptr_q)) begin
        found_hi = 1'b1;
        hi_idx   = IdxW'(i);
      end
    end
    idx_o = found_hi ? hi_idx : lo_idx;
    for (int unsigned i = 0; i < NumReq; i++) begin
      grant_o[i] = found_lo && (IdxW'(i) == idx_o);
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (idx_o == IdxW'(NumReq - 1)) ? '0 : idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ltl_monitor_cluster_reporter.sv
// Per-cluster LTL monitor: registered hits, sticky flags, saturating counters and a
// timestamped violation-event stream towards the logger.
module ltl_monitor_cluster_reporter
  import ltl_monitor_pkg::*;
#(
  parameter int unsigned NumProps  = DefNumProps,
  parameter int unsigned NumReport = DefNumReport,
  parameter int unsigned CntW      = DefCntW,
  parameter int unsigned TsW       = DefTsW,
  parameter int unsigned PidW      = DefPidW
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          run_i,
  input  logic [NumProps*NumReport-1:0] report_states_i,
  input  logic [NumProps-1:0]           prop_enable_i,
  input  logic [NumProps-1:0]           clear_sticky_i,
  input  logic                          clear_counts_i,
  output logic [NumProps-1:0]           ltl_hit_o,
  output logic [NumProps-1:0]           ltl_sticky_o,
  output logic [NumProps*CntW-1:0]      hit_counts_o,
  output logic                          evt_valid_o,
  input  logic                          evt_ready_i,
  output logic [PidW-1:0]               evt_prop_id_o,
  output logic [TsW-1:0]                evt_timestamp_o,
  output logic                          evt_overflow_o
);

  logic [NumProps-1:0]      raw_hit;
  logic [TsW-1:0]           ts_q;
  logic [NumProps-1:0]      hit_q, sticky_q;
  logic [NumProps*CntW-1:0] counts_q;
  logic [NumProps-1:0]      pend_q, pend_d, ovf_q, ovf_d;
  logic [TsW-1:0]           ts_cap_q [NumProps];
  logic [TsW-1:0]           ts_cap_d [NumProps];

  evt_state_e      state_q;
  logic            evt_valid_q, evt_ovf_q;
  logic [PidW-1:0] evt_id_q;
  logic [TsW-1:0]  evt_ts_q;

  logic                do_grant;
  logic [NumProps-1:0] gnt_oh, gnt_clr;
  logic [PidW-1:0]     gnt_idx;
  logic [TsW-1:0]      gnt_ts;
  logic                gnt_ovf;

  always_comb begin
    for (int unsigned p = 0; p < NumProps; p++) begin
      raw_hit[p] = run_i & prop_enable_i[p] & (|report_states_i[p*NumReport +: NumReport]);
    end
  end

  // A new grant is possible whenever the output register is empty or being consumed.
  assign do_grant = (|pend_q) && ((state_q == StIdle) || evt_ready_i);
  assign gnt_clr  = do_grant ? gnt_oh : '0;

  ltl_rr_arbiter #(
    .NumReq (NumProps),
    .IdxW   (PidW)
  ) u_arb (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .req_i     (pend_q),
    .advance_i (do_grant),
    .grant_o   (gnt_oh),
    .idx_o     (gnt_idx)
  );

  always_comb begin
    gnt_ts  = '0;
    gnt_ovf = 1'b0;
    for (int unsigned p = 0; p < NumProps; p++) begin
      if (gnt_oh[p]) begin
        gnt_ts  = ts_cap_q[p];
        gnt_ovf = ovf_q[p];
      end
    end
  end

  // Granted entries are released first, so a coincident hit opens a fresh entry.
  always_comb begin
    pend_d   = pend_q & ~gnt_clr;
    ovf_d    = ovf_q & ~gnt_clr;
    ts_cap_d = ts_cap_q;
    for (int unsigned p = 0; p < NumProps; p++) begin
      if (raw_hit[p]) begin
        if (!pend_d[p]) begin
          pend_d[p]   = 1'b1;
          ovf_d[p]    = 1'b0;
          ts_cap_d[p] = ts_q;
        end else begin
          ovf_d[p] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ts_q     <= '0;
      hit_q    <= '0;
      sticky_q <= '0;
      counts_q <= '0;
      pend_q   <= '0;
      ovf_q    <= '0;
      for (int unsigned p = 0; p < NumProps; p++) begin
        ts_cap_q[p] <= '0;
      end
    end else begin
      if (run_i) begin
        ts_q <= ts_q + 1'b1;
      end
      hit_q    <= raw_hit;
      sticky_q <= (sticky_q & ~clear_sticky_i) | raw_hit;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      ts_cap_q <= ts_cap_d;
      for (int unsigned p = 0; p < NumProps; p++) begin
        if (clear_counts_i) begin
          counts_q[p*CntW +: CntW] <= '0;
        end else if (raw_hit[p] && (counts_q[p*CntW +: CntW] != {CntW{1'b1}})) begin
          counts_q[p*CntW +: CntW] <= counts_q[p*CntW +: CntW] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      evt_ts_q    <= '0;
      evt_ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (do_grant) begin
            state_q     <= StPresent;
            evt_valid_q <= 1'b1;
            evt_id_q    <= gnt_idx;
            evt_ts_q    <= gnt_ts;
            evt_ovf_q   <= gnt_ovf;
          end
        end
        StPresent: begin
          if (evt_ready_i) begin
            if (do_grant) begin
              evt_id_q  <= gnt_idx;
              evt_ts_q  <= gnt_ts;
              evt_ovf_q <= gnt_ovf;
            end else begin
              state_q     <= StIdle;
              evt_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= StIdle;
          evt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ltl_hit_o       = hit_q;
  assign ltl_sticky_o    = sticky_q;
  assign hit_counts_o    = counts_q;
  assign evt_valid_o     = evt_valid_q;
  assign evt_prop_id_o   = evt_id_q;
  assign evt_timestamp_o = evt_ts_q;
  assign evt_overflow_o  = evt_ovf_q;

endmodule

// File: tb/tb_ltl_monitor_cluster_reporter.sv
// Directed bench: default-width reporter plus a 4-bit-counter instance sharing the stimulus.
module tb_ltl_monitor_cluster_reporter;

  logic        clk = 1'b0;
  logic        reset, run, clear_counts, evt_ready;
  logic [39:0] report_states;
  logic [9:0]  prop_enable, clear_sticky;

  logic [9:0]   ltl_hit, ltl_sticky;
  logic [159:0] hit_counts;
  logic         evt_valid, evt_overflow;
  logic [4:0]   evt_prop_id;
  logic [31:0]  evt_timestamp;

  logic [9:0]  c4_hit, c4_sticky;
  logic [39:0] c4_counts;
  logic        c4_valid, c4_ovf;
  logic [4:0]  c4_id;
  logic [31:0] c4_ts;

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned ts_m = 0;
  int unsigned ts5;

  always #5 clk = ~clk;

  ltl_monitor_cluster_reporter dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .run_i           (run),
    .report_states_i (report_states),
    .prop_enable_i   (prop_enable),
    .clear_sticky_i  (clear_sticky),
    .clear_counts_i  (clear_counts),
    .ltl_hit_o       (ltl_hit),
    .ltl_sticky_o    (ltl_sticky),
    .hit_counts_o    (hit_counts),
    .evt_valid_o     (evt_valid),
    .evt_ready_i     (evt_ready),
    .evt_prop_id_o   (evt_prop_id),
    .evt_timestamp_o (evt_timestamp),
    .evt_overflow_o  (evt_overflow)
  );

  ltl_monitor_cluster_reporter #(
    .CntW (4)
  ) dut_c4 (
    .clk_i           (clk),
    .reset_i         (reset),
    .run_i           (run),
    .report_states_i (report_states),
    .prop_enable_i   (prop_enable),
    .clear_sticky_i  (clear_sticky),
    .clear_counts_i  (clear_counts),
    .ltl_hit_o       (c4_hit),
    .ltl_sticky_o    (c4_sticky),
    .hit_counts_o    (c4_counts),
    .evt_valid_o     (c4_valid),
    .evt_ready_i     (evt_ready),
    .evt_prop_id_o   (c4_id),
    .evt_timestamp_o (c4_ts),
    .evt_overflow_o  (c4_ovf)
  );

  // One clock; ts_m tracks the timestamp the DUT holds after the edge.
  task automatic step();
    if (reset) ts_m = 0;
    else if (run) ts_m++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    evt_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i >= 2 && !evt_valid && !c4_valid) break;
    end
    n_checks++;
    if (evt_valid !== 1'b0 || c4_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL drain: valid=%b/%b required 0/0", evt_valid, c4_valid);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; clear_counts = 1'b0; evt_ready = 1'b0;
    report_states = '0; prop_enable = '1; clear_sticky = '0;
    step(); step();
    reset = 1'b0;
    step();
    n_checks++;
    if (ltl_hit !== 10'd0 || ltl_sticky !== 10'd0 || hit_counts !== 160'd0) begin
      n_errors++;
      $display("FAIL reset_state: hit=%h sticky=%h counts=%h required 0", ltl_hit, ltl_sticky,
               hit_counts);
    end
    n_checks++;
    if (evt_valid !== 1'b0 || evt_prop_id !== 5'd0 || evt_timestamp !== 32'd0 ||
        evt_overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_evt: v=%b id=%0d ts=%0d ovf=%b required all 0", evt_valid,
               evt_prop_id, evt_timestamp, evt_overflow);
    end
  endtask

  task automatic test_single_hit();
    run = 1'b1;
    while (ts_m < 5) step();
    report_states[2] = 1'b1;
    step();
    report_states = '0;
    n_checks++;
    if (ltl_hit !== 10'b1 || ltl_sticky[0] !== 1'b1 || hit_counts[15:0] !== 16'd1) begin
      n_errors++;
      $display("FAIL single_hit: hit=%b sticky0=%b cnt0=%0d required 0000000001/1/1", ltl_hit,
               ltl_sticky[0], hit_counts[15:0]);
    end
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL single_early_valid: valid=%b required 0", evt_valid);
    end
    step();
    n_checks++;
    if (evt_valid !== 1'b1 || evt_prop_id !== 5'd0 || evt_timestamp !== 32'd5 ||
        evt_overflow !== 1'b0 || ltl_hit !== 10'd0) begin
      n_errors++;
      $display("FAIL single_evt: v=%b id=%0d ts=%0d ovf=%b hit=%b required 1/0/5/0/0",
               evt_valid, evt_prop_id, evt_timestamp, evt_overflow, ltl_hit);
    end
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL single_accept: valid=%b required 0", evt_valid);
    end
  endtask

  task automatic test_back_to_back();
    while (ts_m < 20) step();
    report_states[4] = 1'b1; report_states[12] = 1'b1; report_states[28] = 1'b1;
    step();
    n_checks++;
    if (ltl_hit !== 10'b0010001010) begin
      n_errors++;
      $display("FAIL b2b_hit: hit=%b required 0010001010", ltl_hit);
    end
    report_states = '0;
    report_states[12] = 1'b1; report_states[28] = 1'b1;
    step();
    report_states = '0;
    step(); step();
    n_checks++;
    if (evt_valid !== 1'b1 || evt_prop_id !== 5'd1 || evt_timestamp !== 32'd20 ||
        evt_overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_first: v=%b id=%0d ts=%0d ovf=%b required 1/1/20/0", evt_valid,
               evt_prop_id, evt_timestamp, evt_overflow);
    end
    evt_ready = 1'b1;
    step();
    n_checks++;
    if (evt_valid !== 1'b1 || evt_prop_id !== 5'd3 || evt_timestamp !== 32'd20 ||
        evt_overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_second: v=%b id=%0d ts=%0d ovf=%b required 1/3/20/1", evt_valid,
               evt_prop_id, evt_timestamp, evt_overflow);
    end
    step();
    n_checks++;
    if (evt_valid !== 1'b1 || evt_prop_id !== 5'd7 || evt_timestamp !== 32'd20 ||
        evt_overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_third: v=%b id=%0d ts=%0d ovf=%b required 1/7/20/1", evt_valid,
               evt_prop_id, evt_timestamp, evt_overflow);
    end
    step();
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_empty: valid=%b required 0", evt_valid);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_saturation();
    report_states[36] = 1'b1;
    for (int i = 0; i < 20; i++) step();
    n_checks++;
    if (c4_counts[39:36] !== 4'd15 || hit_counts[159:144] !== 16'd20) begin
      n_errors++;
      $display("FAIL sat_count: c4=%0d wide=%0d required 15/20", c4_counts[39:36],
               hit_counts[159:144]);
    end
    step(); step(); step();
    n_checks++;
    if (c4_counts[39:36] !== 4'd15) begin
      n_errors++;
      $display("FAIL sat_hold: c4=%0d required 15", c4_counts[39:36]);
    end
    report_states = '0;
    clear_counts = 1'b1;
    step();
    clear_counts = 1'b0;
    n_checks++;
    if (c4_counts !== 40'd0 || hit_counts !== 160'd0) begin
      n_errors++;
      $display("FAIL sat_clear: c4=%h wide=%h required 0", c4_counts, hit_counts);
    end
    clear_counts = 1'b1;
    report_states[36] = 1'b1;
    step();
    clear_counts = 1'b0;
    n_checks++;
    if (c4_counts[39:36] !== 4'd0) begin
      n_errors++;
      $display("FAIL sat_clear_vs_hit: c4=%0d required 0", c4_counts[39:36]);
    end
    step();
    report_states = '0;
    n_checks++;
    if (c4_counts[39:36] !== 4'd1) begin
      n_errors++;
      $display("FAIL sat_restart: c4=%0d required 1", c4_counts[39:36]);
    end
    drain();
  endtask

  task automatic test_disable();
    prop_enable[4] = 1'b0;
    report_states[16] = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_checks++;
    if (ltl_hit[4] !== 1'b0 || ltl_sticky[4] !== 1'b0 || hit_counts[79:64] !== 16'd0) begin
      n_errors++;
      $display("FAIL disable_prop: hit=%b sticky=%b cnt=%0d required 0/0/0", ltl_hit[4],
               ltl_sticky[4], hit_counts[79:64]);
    end
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL disable_evt: valid=%b required 0", evt_valid);
    end
    report_states = '0;
    prop_enable = '1;
  endtask

  task automatic test_sticky();
    report_states[8] = 1'b1;
    clear_sticky[2] = 1'b1;
    step();
    report_states = '0;
    clear_sticky = '0;
    n_checks++;
    if (ltl_sticky[2] !== 1'b1) begin
      n_errors++;
      $display("FAIL sticky_set_wins: sticky2=%b required 1", ltl_sticky[2]);
    end
    step(); step();
    clear_sticky[2] = 1'b1;
    step();
    clear_sticky = '0;
    n_checks++;
    if (ltl_sticky[2] !== 1'b0) begin
      n_errors++;
      $display("FAIL sticky_clear: sticky2=%b required 0", ltl_sticky[2]);
    end
    drain();
  endtask

  task automatic test_freeze_and_reset();
    ts5 = ts_m;
    report_states[20] = 1'b1;
    step();
    report_states = '0;
    run = 1'b0;
    step();
    for (int i = 0; i < 10; i++) step();
    n_checks++;
    if (evt_valid !== 1'b1 || evt_prop_id !== 5'd5 || evt_timestamp !== ts5 ||
        evt_overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL freeze_stable: v=%b id=%0d ts=%0d ovf=%b required 1/5/%0d/0", evt_valid,
               evt_prop_id, evt_timestamp, evt_overflow, ts5);
    end
    run = 1'b1;
    report_states[24] = 1'b1;
    step();
    report_states = '0;
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    n_checks++;
    if (evt_valid !== 1'b1 || evt_prop_id !== 5'd6 || evt_timestamp !== ts5 + 1) begin
      n_errors++;
      $display("FAIL freeze_ts: v=%b id=%0d ts=%0d required 1/6/%0d", evt_valid, evt_prop_id,
               evt_timestamp, ts5 + 1);
    end
    report_states[28] = 1'b1;
    step();
    report_states = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (evt_valid !== 1'b0 || ltl_hit !== 10'd0 || ltl_sticky !== 10'd0 ||
        hit_counts !== 160'd0) begin
      n_errors++;
      $display("FAIL midrun_reset: v=%b hit=%b sticky=%b counts=%h required 0", evt_valid,
               ltl_hit, ltl_sticky, hit_counts);
    end
    report_states[0] = 1'b1;
    step();
    report_states = '0;
    step();
    n_checks++;
    if (evt_valid !== 1'b1 || evt_prop_id !== 5'd0 || evt_timestamp !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_ts: v=%b id=%0d ts=%0d required 1/0/0", evt_valid, evt_prop_id,
               evt_timestamp);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_back_to_back();
    test_saturation();
    test_disable();
    test_sticky();
    test_freeze_and_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
